foodfight_input_cond: RTL and testbench



---
 rtl/foodfight_input_cond_if.sv | 38 +++
 rtl/foodfight_input_cond.sv | 169 ++++++++++++++++
 tb/tb_foodfight_input_cond.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/foodfight_input_cond_if.sv
// Signal bundle between the cabinet/auto-input side and the Food Fight input
// conditioner. The board side (master) drives the raw active-low switches and
// the auto strobes; the conditioner (slave) returns the clean levels, the
// shaped coin, the coin meter/counter and its coin FSM state for observation.
//
// There is no valid/ready handshake on this bundle: every signal is a level.
// The raw switches are asynchronous. The auto strobes are synchronous to
// clk6m. All outputs are registered in clk6m.
interface foodfight_input_cond_if;
  // raw cabinet switches, active low, asynchronous
  logic       coin_n;
  logic       start_n;
  logic       throw_n;
  // auto strobes from the reset/auto-input generator, active low, clk6m domain
  logic       auto_coin_n;
  logic       auto_start_n;
  logic       auto_throw_n;
  // conditioned outputs to the CPU input port
  logic       coin_n_o;
  logic       start_n_o;
  logic       throw_n_o;
  logic       coin_meter;
  logic [7:0] coin_count;
  // coin FSM state: 0 IDLE, 1 ACTIVE, 2 WAIT_REL, 3 LOCKOUT
  logic [1:0] coin_state;

  modport master (
    output coin_n, start_n, throw_n,
    output auto_coin_n, auto_start_n, auto_throw_n,
    input  coin_n_o, start_n_o, throw_n_o, coin_meter, coin_count, coin_state
  );

  modport slave (
    input  coin_n, start_n, throw_n,
    input  auto_coin_n, auto_start_n, auto_throw_n,
    output coin_n_o, start_n_o, throw_n_o, coin_meter, coin_count, coin_state
  );
endinterface

// File: rtl/foodfight_input_cond.sv
// Food Fight player-input conditioner (6 MHz pixel domain).
// Each raw switch is synchronized and debounced, then ANDed with its auto
// strobe (both active low). Start and throw are presented as registered
// levels. An accepted coin becomes a fixed-width low pulse, followed by a
// wait for release and a lockout gap, so a held coin counts exactly once.
module foodfight_input_cond #(
  parameter int DB_COUNT   = 60000,
  parameter int COIN_PULSE = 600000,
  parameter int COIN_GAP   = 300000
) (
  input  logic                 clk6m,
  input  logic                 reset,
  foodfight_input_cond_if.slave io
);

  // Channel indices into the per-switch vectors.
  localparam int CH_COIN  = 0;
  localparam int CH_START = 1;
  localparam int CH_THROW = 2;
  localparam int NCH      = 3;

  // Debounce counter only has to reach DB_COUNT-1.
  localparam int DB_W = (DB_COUNT > 2) ? $clog2(DB_COUNT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

  // One coin timer serves both the pulse and the lockout gap.
  localparam int TMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PULSE_LAST = TW'(COIN_PULSE - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(COIN_GAP - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    WAIT_REL = 2'd2,
    LOCKOUT  = 2'd3
  } coin_state_t;

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  sync1;
  logic [NCH-1:0]  sync2;
  logic [NCH-1:0]  stable;
  logic [DB_W-1:0] db_cnt [NCH];

  logic eff_coin;
  logic eff_start;
  logic eff_throw;

  logic start_q;
  logic throw_q;

  coin_state_t     state;
  logic [TW-1:0]   timer;
  logic            coin_q;
  logic            meter_q;
  logic [7:0]      count_q;

  assign raw[CH_COIN]  = io.coin_n;
  assign raw[CH_START] = io.start_n;
  assign raw[CH_THROW] = io.throw_n;

  // Two-flop synchronizer for the asynchronous switches; idles at "released".
  always_ff @(posedge clk6m) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: accept a new level only after DB_COUNT consecutive
  // mismatching cycles; any matching cycle restarts the count.
  always_ff @(posedge clk6m) begin
    if (reset) begin
      stable <= '1;
      for (int i = 0; i < NCH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Either source pulling low asserts the input; no arbitration is needed.
  assign eff_coin  = stable[CH_COIN]  & io.auto_coin_n;
  assign eff_start = stable[CH_START] & io.auto_start_n;
  assign eff_throw = stable[CH_THROW] & io.auto_throw_n;

  // Register start/throw so no input reaches an output combinationally.
  always_ff @(posedge clk6m) begin
    if (reset) begin
      start_q <= 1'b1;
      throw_q <= 1'b1;
    end else begin
      start_q <= eff_start;
      throw_q <= eff_throw;
    end
  end

  // Coin FSM: pulse for COIN_PULSE cycles, wait for release, then hold off
  // new coins for COIN_GAP cycles. The counter wraps naturally at 256.
  always_ff @(posedge clk6m) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      coin_q  <= 1'b1;
      meter_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!eff_coin) begin
            state   <= ACTIVE;
            timer   <= PULSE_LAST;
            coin_q  <= 1'b0;
            meter_q <= 1'b1;
            count_q <= count_q + 8'd1;
          end
        end
        ACTIVE: begin
          if (timer == '0) begin
            state   <= WAIT_REL;
            coin_q  <= 1'b1;
            meter_q <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        WAIT_REL: begin
          // A stuck switch or long strobe parks here until it lets go.
          if (eff_coin) begin
            state <= LOCKOUT;
            timer <= GAP_LAST;
          end
        end
        LOCKOUT: begin
          // Coin input is deliberately ignored in this state.
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io.coin_n_o   = coin_q;
  assign io.start_n_o  = start_q;
  assign io.throw_n_o  = throw_q;
  assign io.coin_meter = meter_q;
  assign io.coin_count = count_q;
  assign io.coin_state = state;

endmodule

// File: tb/tb_foodfight_input_cond.sv
// Directed bench for foodfight_input_cond with DB_COUNT=4, COIN_PULSE=8,
// COIN_GAP=4. Inputs are driven 1 time unit after a rising edge, so a change
// driven after tick k is first sampled at edge N = k+1; outputs are read at
// the same offset after each edge.
module tb_foodfight_input_cond;

  localparam int DB_COUNT   = 4;
  localparam int COIN_PULSE = 8;
  localparam int COIN_GAP   = 4;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  logic clk6m;
  logic reset;
  int   nchk;
  int   nerr;

  foodfight_input_cond_if io_if ();

  foodfight_input_cond #(
    .DB_COUNT   (DB_COUNT),
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP)
  ) dut (
    .clk6m (clk6m),
    .reset (reset),
    .io    (io_if)
  );

  // ---------------- clock / reset ----------------
  initial clk6m = 1'b0;
  always #5 clk6m = ~clk6m;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk6m);
    #1;
  endtask

  task automatic inputs_idle();
    io_if.coin_n       = 1'b1;
    io_if.start_n      = 1'b1;
    io_if.throw_n      = 1'b1;
    io_if.auto_coin_n  = 1'b1;
    io_if.auto_start_n = 1'b1;
    io_if.auto_throw_n = 1'b1;
  endtask

  task automatic do_reset();
    inputs_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    io_if.coin_n       = 1'b0;
    io_if.start_n      = 1'b0;
    io_if.throw_n      = 1'b0;
    io_if.auto_coin_n  = 1'b1;
    io_if.auto_start_n = 1'b1;
    io_if.auto_throw_n = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++;
      if ({io_if.coin_n_o, io_if.start_n_o, io_if.throw_n_o, io_if.coin_meter} !== 4'b1110) begin
        nerr++;
        $display("FAIL reset_outs cyc%0d: got %b want 1110", i,
                 {io_if.coin_n_o, io_if.start_n_o, io_if.throw_n_o, io_if.coin_meter});
      end
      nchk++;
      if (io_if.coin_count !== 8'd0) begin
        nerr++;
        $display("FAIL reset_count cyc%0d: got %0d want 0", i, io_if.coin_count);
      end
    end
    reset = 1'b0;
    // Inputs already low: seen at edge N+6 (7th tick after release).
    for (int t = 1; t <= 7; t++) begin
      tick();
      nchk++;
      if (io_if.start_n_o !== ((t < 7) ? 1'b1 : 1'b0)) begin
        nerr++;
        $display("FAIL reset_start_latency tick%0d: got %b want %b", t, io_if.start_n_o, (t < 7));
      end
      nchk++;
      if (io_if.coin_n_o !== ((t < 7) ? 1'b1 : 1'b0)) begin
        nerr++;
        $display("FAIL reset_coin_latency tick%0d: got %b want %b", t, io_if.coin_n_o, (t < 7));
      end
    end
    nchk++;
    if (io_if.throw_n_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_throw_low: got %b want 0", io_if.throw_n_o);
    end
    nchk++;
    if (io_if.coin_count !== 8'd1) begin
      nerr++;
      $display("FAIL reset_coin_count_after: got %0d want 1", io_if.coin_count);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    io_if.start_n = 1'b0;
    tick();
    tick();
    tick();
    io_if.start_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      nchk++;
      if (io_if.start_n_o !== 1'b1) begin
        nerr++;
        $display("FAIL glitch_reject tick%0d: got %b want 1", t, io_if.start_n_o);
      end
    end
    io_if.start_n = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      nchk++;
      if (io_if.start_n_o !== ((t < 7) ? 1'b1 : 1'b0)) begin
        nerr++;
        $display("FAIL glitch_press tick%0d: got %b want %b", t, io_if.start_n_o, (t < 7));
      end
    end
    io_if.start_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      nchk++;
      if (io_if.start_n_o !== ((t < 7) ? 1'b0 : 1'b1)) begin
        nerr++;
        $display("FAIL glitch_release tick%0d: got %b want %b", t, io_if.start_n_o, (t >= 7));
      end
    end
  endtask

  task automatic test_auto_throw();
    do_reset();
    nchk++;
    if (io_if.throw_n_o !== 1'b1) begin
      nerr++;
      $display("FAIL auto_throw_before: got %b want 1", io_if.throw_n_o);
    end
    io_if.auto_throw_n = 1'b0;
    tick();
    io_if.auto_throw_n = 1'b1;
    nchk++;
    if (io_if.throw_n_o !== 1'b0) begin
      nerr++;
      $display("FAIL auto_throw_pulse: got %b want 0", io_if.throw_n_o);
    end
    tick();
    nchk++;
    if (io_if.throw_n_o !== 1'b1) begin
      nerr++;
      $display("FAIL auto_throw_after: got %b want 1", io_if.throw_n_o);
    end
    // Auto start also feeds its output one edge later.
    io_if.auto_start_n = 1'b0;
    tick();
    io_if.auto_start_n = 1'b1;
    nchk++;
    if (io_if.start_n_o !== 1'b0) begin
      nerr++;
      $display("FAIL auto_start_pulse: got %b want 0", io_if.start_n_o);
    end
  endtask

  task automatic test_coin_shaping();
    int low_cnt;
    int meter_cnt;
    int falls;
    int first_low;
    int waited;
    logic prev;
    do_reset();
    low_cnt   = 0;
    meter_cnt = 0;
    falls     = 0;
    first_low = -1;
    prev      = 1'b1;
    io_if.coin_n = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (io_if.coin_n_o === 1'b0) low_cnt++;
      if (io_if.coin_meter === 1'b1) meter_cnt++;
      if (prev === 1'b1 && io_if.coin_n_o === 1'b0) begin
        falls++;
        if (first_low < 0) first_low = t;
      end
      prev = io_if.coin_n_o;
    end
    io_if.coin_n = 1'b1;
    waited = 0;
    while (io_if.coin_state !== ST_LOCKOUT && waited < 20) begin
      tick();
      waited++;
      if (io_if.coin_n_o === 1'b0) low_cnt++;
      if (io_if.coin_meter === 1'b1) meter_cnt++;
    end
    nchk++;
    if (first_low !== 7) begin
      nerr++;
      $display("FAIL coin_latency: got tick %0d want 7", first_low);
    end
    nchk++;
    if (low_cnt !== COIN_PULSE) begin
      nerr++;
      $display("FAIL coin_pulse_width: got %0d want %0d", low_cnt, COIN_PULSE);
    end
    nchk++;
    if (meter_cnt !== COIN_PULSE) begin
      nerr++;
      $display("FAIL coin_meter_width: got %0d want %0d", meter_cnt, COIN_PULSE);
    end
    nchk++;
    if (falls !== 1) begin
      nerr++;
      $display("FAIL coin_single_pulse: got %0d want 1", falls);
    end
    nchk++;
    if (io_if.coin_count !== 8'd1) begin
      nerr++;
      $display("FAIL coin_count_one: got %0d want 1", io_if.coin_count);
    end
    nchk++;
    if (io_if.coin_state !== ST_LOCKOUT) begin
      nerr++;
      $display("FAIL coin_reach_lockout: got state %0d want 3", io_if.coin_state);
    end
    // Strobe during LOCKOUT must be ignored.
    io_if.auto_coin_n = 1'b0;
    tick();
    io_if.auto_coin_n = 1'b1;
    low_cnt = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (io_if.coin_n_o === 1'b0) low_cnt++;
    end
    nchk++;
    if (low_cnt !== 0) begin
      nerr++;
      $display("FAIL coin_lockout_ignore_pulse: got %0d low cycles want 0", low_cnt);
    end
    nchk++;
    if (io_if.coin_count !== 8'd1) begin
      nerr++;
      $display("FAIL coin_lockout_ignore_count: got %0d want 1", io_if.coin_count);
    end
    // Fresh press after lockout is accepted.
    io_if.coin_n = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
    end
    io_if.coin_n = 1'b1;
    nchk++;
    if (io_if.coin_count !== 8'd2) begin
      nerr++;
      $display("FAIL coin_second_count: got %0d want 2", io_if.coin_count);
    end
    for (int t = 1; t <= 25; t++) begin
      tick();
    end
  endtask

  task automatic test_wrap();
    int low_cnt;
    int meter_cnt;
    logic [7:0] exp_count;
    do_reset();
    exp_count = 8'd0;
    for (int k = 0; k < 256; k++) begin
      io_if.auto_coin_n = 1'b0;
      tick();
      io_if.auto_coin_n = 1'b1;
      exp_count = exp_count + 8'd1;
      nchk++;
      if (io_if.coin_count !== exp_count) begin
        nerr++;
        $display("FAIL wrap_count k%0d: got %0d want %0d", k, io_if.coin_count, exp_count);
      end
      low_cnt   = 0;
      meter_cnt = 0;
      for (int t = 0; t < 16; t++) begin
        if (t > 0) tick();
        if (io_if.coin_n_o === 1'b0) low_cnt++;
        if (io_if.coin_meter === 1'b1) meter_cnt++;
      end
      nchk++;
      if (low_cnt !== COIN_PULSE || meter_cnt !== COIN_PULSE) begin
        nerr++;
        $display("FAIL wrap_width k%0d: got low %0d meter %0d want %0d", k, low_cnt, meter_cnt, COIN_PULSE);
      end
    end
    nchk++;
    if (io_if.coin_count !== 8'd0) begin
      nerr++;
      $display("FAIL wrap_final: got %0d want 0", io_if.coin_count);
    end
  endtask

  task automatic test_reset_mid_active();
    int waited;
    do_reset();
    io_if.coin_n = 1'b0;
    waited = 0;
    while (io_if.coin_n_o !== 1'b0 && waited < 20) begin
      tick();
      waited++;
    end
    nchk++;
    if (io_if.coin_n_o !== 1'b0) begin
      nerr++;
      $display("FAIL rma_pulse_start: got %b want 0", io_if.coin_n_o);
    end
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    nchk++;
    if ({io_if.coin_n_o, io_if.coin_meter} !== 2'b10) begin
      nerr++;
      $display("FAIL rma_abort: got coin_n_o/meter %b want 10", {io_if.coin_n_o, io_if.coin_meter});
    end
    nchk++;
    if (io_if.coin_count !== 8'd0) begin
      nerr++;
      $display("FAIL rma_count: got %0d want 0", io_if.coin_count);
    end
    reset = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      nchk++;
      if (io_if.coin_n_o !== ((t < 7) ? 1'b1 : 1'b0)) begin
        nerr++;
        $display("FAIL rma_restart tick%0d: got %b want %b", t, io_if.coin_n_o, (t < 7));
      end
    end
    nchk++;
    if (io_if.coin_count !== 8'd1) begin
      nerr++;
      $display("FAIL rma_restart_count: got %0d want 1", io_if.coin_count);
    end
    io_if.coin_n = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nchk  = 0;
    nerr  = 0;
    reset = 1'b1;
    inputs_idle();
    test_reset();
    test_glitch();
    test_auto_throw();
    test_coin_shaping();
    test_wrap();
    test_reset_mid_active();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
